ar_burst_issuer: RTL

- Parametrised successor to the single-request AR driver in the transaction_layer_rx path.
- Buffers up to DEPTH Memory-Read request headers from tlp_demux.
- Splits each request into AXI4 INCR bursts that obey two limits: at most MAX_BURST_BEATS beats, and no 4 KB boundary crossing.
- Drives a spec-compliant AR master channel: valid and payload are held stable until ready. A per-burst issue strobe tells the completion builder how to reassemble the bursts.

---
 rtl/ar_burst_issuer.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ar_burst_issuer.sv
// ar_burst_issuer
//   Buffers Memory-Read request headers and replays each one as a sequence of
//   AXI4 INCR read bursts on an AR master channel. A burst never exceeds
//   MAX_BURST_BEATS beats and never crosses a 4 KB page. Each AR handshake is
//   reported one cycle later on issue_fire/issue_tag/issue_last so the
//   completion builder can stitch the bursts back together.
//   Optional build macro: AR_PERF_CNT_EN adds perf_req_cnt / perf_burst_cnt.
//
//   PCIE_PKG defines the request-header layout used by tlp_demux:
//     hdr[31:0]   DW0: [29] 4DW format, [23] tag[9], [19] tag[8], [9:0] length (DW)
//     hdr[63:32]  DW1: [15:8] tag[7:0]
//     hdr[95:64]  DW2: 3DW -> address[31:2]; 4DW -> address[63:32]
//     hdr[127:96] DW3: 4DW -> address[31:2]

package PCIE_PKG;

   localparam int ADDR_WIDTH = 64;

   // Request byte address; 3DW headers carry a 32-bit address in DW2.
   function automatic logic [63:0] get_addr_from_req_hdr(input logic [127:0] hdr);
      logic [63:0] addr_s;
      if (hdr[29]) begin
         addr_s = {hdr[95:64], hdr[127:98], 2'b00};
      end else begin
         addr_s = {32'h0000_0000, hdr[95:66], 2'b00};
      end
      return addr_s;
   endfunction

   // Length field in DW; 0 encodes 1024 DW.
   function automatic logic [9:0] get_len_dw_from_req_hdr(input logic [127:0] hdr);
      return hdr[9:0];
   endfunction

   // 10-bit tag: T9 and T8 live in DW0, the low byte in DW1.
   function automatic logic [9:0] get_tag_from_req_hdr(input logic [127:0] hdr);
      return {hdr[23], hdr[19], hdr[47:40]};
   endfunction

endpackage

module ar_burst_issuer #(
   parameter int ADDR_WIDTH      = PCIE_PKG::ADDR_WIDTH,
   parameter int DATA_WIDTH      = 256,
   parameter int ID_WIDTH        = 8,
   parameter int MAX_BURST_BEATS = 16,
   parameter int DEPTH           = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hdr_wren,
   input  logic [127:0]          hdr_data,
   output logic                  hdr_ready,
   output logic                  ar_valid,
   input  logic                  ar_ready,
   output logic [ADDR_WIDTH-1:0] ar_addr,
   output logic [ID_WIDTH-1:0]   ar_id,
   output logic [7:0]            ar_len,
   output logic [2:0]            ar_size,
   output logic [1:0]            ar_burst,
   output logic                  issue_fire,
   output logic [9:0]            issue_tag,
   output logic                  issue_last,
   output logic                  ar_busy,
   output logic                  overflow_err
`ifdef AR_PERF_CNT_EN
   ,
   output logic [31:0]           perf_req_cnt,
   output logic [31:0]           perf_burst_cnt
`endif
);

   localparam int          BPB         = DATA_WIDTH / 8;
   localparam int          LOG_BPB     = $clog2(BPB);
   localparam logic [31:0] BPB_MASK    = 32'(BPB - 1);
   localparam logic [31:0] BURST_BYTES = 32'(MAX_BURST_BEATS * BPB);
   localparam int          PTR_W       = $clog2(DEPTH);
   localparam int          CNT_W       = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   // Decoded request kept in the FIFO: start address, byte count, tag.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [12:0]           bytes;
      logic [9:0]            tag;
   } entry_t;

   // One burst: AXI length field and how many request bytes it consumes.
   typedef struct packed {
      logic [7:0]  len;
      logic [12:0] step;
   } burst_t;

   // Bytes this burst may cover from cur: limited by the remaining request,
   // the beat cap (measured from the beat-aligned start) and the 4 KB page.
   function automatic burst_t calc_burst(input logic [11:0] cur_lo, input logic [12:0] rem);
      logic [31:0] off_s;
      logic [31:0] d_max_s;
      logic [31:0] d_4k_s;
      logic [31:0] step_s;
      logic [31:0] beats_s;
      burst_t      b_s;
      off_s   = 32'(cur_lo) & BPB_MASK;
      d_max_s = BURST_BYTES - off_s;
      d_4k_s  = 32'd4096 - 32'(cur_lo);
      step_s  = 32'(rem);
      if (d_max_s < step_s) begin
         step_s = d_max_s;
      end else begin
         step_s = step_s;
      end
      if (d_4k_s < step_s) begin
         step_s = d_4k_s;
      end else begin
         step_s = step_s;
      end
      beats_s  = (step_s + off_s + BPB_MASK) >> LOG_BPB;
      b_s.len  = 8'(beats_s - 32'd1);
      b_s.step = 13'(step_s);
      return b_s;
   endfunction

   entry_t                fifo_mem_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  overflow_r;

   state_t                state_r;
   logic                  ar_valid_r;
   logic [ADDR_WIDTH-1:0] ar_addr_r;
   logic [ID_WIDTH-1:0]   ar_id_r;
   logic [7:0]            ar_len_r;
   logic [ADDR_WIDTH-1:0] next_addr_r;
   logic [12:0]           rem_r;
   logic [9:0]            tag_r;
   logic                  issue_fire_r;
   logic [9:0]            issue_tag_r;
   logic                  issue_last_r;

   entry_t                new_entry_s;
   entry_t                head_s;
   logic [9:0]            len_dw_s;
   logic                  full_s;
   logic                  pop_s;
   logic                  wr_s;
   logic                  hs_s;
   logic [ADDR_WIDTH-1:0] src_addr_s;
   logic [12:0]           src_rem_s;
   burst_t                burst_s;

   assign full_s = (count_r == CNT_W'(DEPTH));
   assign pop_s  = (state_r == S_LOAD);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign wr_s   = hdr_wren && (!full_s || pop_s);
   assign hs_s   = ar_valid_r && ar_ready;
   assign head_s = fifo_mem_r[rd_ptr_r];

   // Decode an incoming header into address, byte count and tag.
   always_comb begin
      len_dw_s           = PCIE_PKG::get_len_dw_from_req_hdr(hdr_data);
      new_entry_s.addr   = ADDR_WIDTH'(PCIE_PKG::get_addr_from_req_hdr(hdr_data));
      new_entry_s.tag    = PCIE_PKG::get_tag_from_req_hdr(hdr_data);
      if (len_dw_s == 10'd0) begin
         new_entry_s.bytes = 13'd4096;
      end else begin
         new_entry_s.bytes = {1'b0, len_dw_s, 2'b00};
      end
   end

   // Burst source: the FIFO head while loading, otherwise the running cursor.
   always_comb begin
      if (state_r == S_LOAD) begin
         src_addr_s = head_s.addr;
         src_rem_s  = head_s.bytes;
      end else begin
         src_addr_s = next_addr_r;
         src_rem_s  = rem_r;
      end
      burst_s = calc_burst(src_addr_s[11:0], src_rem_s);
   end

   // Header storage; contents need no reset since count_r qualifies them.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         fifo_mem_r[wr_ptr_r] <= new_entry_s;
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + CNT_W'(wr_s) - CNT_W'(pop_s);
         if (hdr_wren && !wr_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Request sequencer: load a header, then hold each burst until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_IDLE;
         ar_valid_r   <= 1'b0;
         ar_addr_r    <= '0;
         ar_id_r      <= '0;
         ar_len_r     <= 8'd0;
         next_addr_r  <= '0;
         rem_r        <= 13'd0;
         tag_r        <= 10'd0;
         issue_fire_r <= 1'b0;
         issue_tag_r  <= 10'd0;
         issue_last_r <= 1'b0;
      end else begin
         issue_fire_r <= hs_s;
         if (hs_s) begin
            issue_tag_r  <= tag_r;
            issue_last_r <= (rem_r == 13'd0);
         end
         case (state_r)
            S_IDLE: begin
               if (count_r != '0) begin
                  state_r <= S_LOAD;
               end
            end
            S_LOAD: begin
               ar_valid_r  <= 1'b1;
               ar_addr_r   <= head_s.addr;
               ar_id_r     <= ID_WIDTH'(head_s.tag);
               tag_r       <= head_s.tag;
               ar_len_r    <= burst_s.len;
               next_addr_r <= head_s.addr + ADDR_WIDTH'(burst_s.step);
               rem_r       <= head_s.bytes - burst_s.step;
               state_r     <= S_ISSUE;
            end
            S_ISSUE: begin
               if (hs_s) begin
                  if (rem_r != 13'd0) begin
                     ar_addr_r   <= next_addr_r;
                     ar_len_r    <= burst_s.len;
                     next_addr_r <= next_addr_r + ADDR_WIDTH'(burst_s.step);
                     rem_r       <= rem_r - burst_s.step;
                  end else begin
                     ar_valid_r <= 1'b0;
                     if (count_r != '0) begin
                        state_r <= S_LOAD;
                     end else begin
                        state_r <= S_IDLE;
                     end
                  end
               end
            end
            default: begin
               state_r    <= S_IDLE;
               ar_valid_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef AR_PERF_CNT_EN
   logic [31:0] perf_req_r;
   logic [31:0] perf_burst_r;

   // Free-running event counters for popped requests and AR handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_req_r   <= 32'd0;
         perf_burst_r <= 32'd0;
      end else begin
         if (pop_s) begin
            perf_req_r <= perf_req_r + 32'd1;
         end
         if (hs_s) begin
            perf_burst_r <= perf_burst_r + 32'd1;
         end
      end
   end

   assign perf_req_cnt   = perf_req_r;
   assign perf_burst_cnt = perf_burst_r;
`endif

   assign hdr_ready    = !full_s;
   assign ar_valid     = ar_valid_r;
   assign ar_addr      = ar_addr_r;
   assign ar_id        = ar_id_r;
   assign ar_len       = ar_len_r;
   assign ar_size      = 3'(LOG_BPB);
   assign ar_burst     = 2'b01;
   assign issue_fire   = issue_fire_r;
   assign issue_tag    = issue_tag_r;
   assign issue_last   = issue_last_r;
   assign ar_busy      = (count_r != '0) || (state_r != S_IDLE);
   assign overflow_err = overflow_r;

endmodule
